// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_ctrl
// Description : Sequences one load/store request from the control unit into
//               one or two 32-bit RAM cycles (byte/halfword/word/doubleword),
//               with alignment checks, lane steering, sign/zero extension and
//               a per-cycle acknowledge timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_ctrl #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mfa,
  input  logic        ld,
  input  logic [1:0]  size,
  input  logic        dword,
  input  logic        sgn,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] wdata_hi,
  output logic [31:0] rdata,
  output logic [31:0] rdata_hi,
  output logic        moc,
  output logic        err,
  output logic        busy,
  output logic        ram_en,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [3:0]  ram_be,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  input  logic        ram_ack
);

  typedef enum logic [1:0] {IDLE, ACC1, ACC2, DONE} state_t;

  // Last wait-count value before the access is abandoned.
  localparam logic [3:0] WAIT_LAST = 4'(TIMEOUT - 1);

  state_t      state, state_nx;
  logic        mfa_q;
  logic        ld_q, dword_q, sgn_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, wdata_hi_q;
  logic        err_q, err_nx;
  logic [3:0]  wait_cnt, wait_nx;
  logic        cap_lo, cap_hi;
  logic        req, bad_req;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_val;

  assign req = mfa & ~mfa_q;

  // Request legality is judged on the live inputs at the accepting edge.
  always_comb begin
    bad_req = 1'b0;
    if (dword) begin
      bad_req = (addr[2:0] != 3'b000);
    end else begin
      case (size)
        2'b11:   bad_req = 1'b1;
        2'b00:   bad_req = addr[0];
        2'b10:   bad_req = (addr[1:0] != 2'b00);
        default: bad_req = 1'b0;
      endcase
    end
  end

  // Next-state, wait counter and capture strobes.
  always_comb begin
    state_nx = state;
    err_nx   = err_q;
    wait_nx  = wait_cnt;
    cap_lo   = 1'b0;
    cap_hi   = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          wait_nx  = 4'd0;
          err_nx   = bad_req;
          state_nx = bad_req ? DONE : ACC1;
        end
      end
      ACC1, ACC2: begin
        if (ram_ack) begin
          wait_nx = 4'd0;
          if (state == ACC1) begin
            cap_lo   = ld_q;
            state_nx = dword_q ? ACC2 : DONE;
          end else begin
            cap_hi   = ld_q;
            state_nx = DONE;
          end
        end else if (wait_cnt == WAIT_LAST) begin
          err_nx   = 1'b1;
          state_nx = DONE;
        end else begin
          wait_nx = wait_cnt + 4'd1;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Lane extraction and extension of the returned word for the first access.
  always_comb begin
    case (addr_q[1:0])
      2'b00:   byte_lane = ram_rdata[7:0];
      2'b01:   byte_lane = ram_rdata[15:8];
      2'b10:   byte_lane = ram_rdata[23:16];
      default: byte_lane = ram_rdata[31:24];
    endcase
    half_lane = addr_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    load_val  = ram_rdata;
    if (!dword_q && size_q == 2'b01) begin
      load_val = {{24{sgn_q & byte_lane[7]}}, byte_lane};
    end else if (!dword_q && size_q == 2'b00) begin
      load_val = {{16{sgn_q & half_lane[15]}}, half_lane};
    end
  end

  // RAM-side drive: active only during the access states, zero otherwise.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = 32'd0;
    ram_be    = 4'b0000;
    ram_wdata = 32'd0;
    if (state == ACC1 || state == ACC2) begin
      ram_en   = 1'b1;
      ram_we   = ~ld_q;
      ram_addr = {addr_q[31:2], 2'b00} + ((state == ACC2) ? 32'd4 : 32'd0);
      if (dword_q) begin
        ram_be    = 4'b1111;
        ram_wdata = (state == ACC2) ? wdata_hi_q : wdata_q;
      end else begin
        case (size_q)
          2'b01: begin
            ram_be    = 4'b0001 << addr_q[1:0];
            ram_wdata = {4{wdata_q[7:0]}};
          end
          2'b00: begin
            ram_be    = addr_q[1] ? 4'b1100 : 4'b0011;
            ram_wdata = {2{wdata_q[15:0]}};
          end
          default: begin
            ram_be    = 4'b1111;
            ram_wdata = wdata_q;
          end
        endcase
      end
    end
  end

  assign moc  = (state == DONE);
  assign err  = (state == DONE) & err_q;
  assign busy = (state != IDLE);

  // State, edge tracker, request latch and load result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      mfa_q      <= 1'b0;
      ld_q       <= 1'b0;
      dword_q    <= 1'b0;
      sgn_q      <= 1'b0;
      size_q     <= 2'b00;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      wdata_hi_q <= 32'd0;
      err_q      <= 1'b0;
      wait_cnt   <= 4'd0;
      rdata      <= 32'd0;
      rdata_hi   <= 32'd0;
    end else begin
      state    <= state_nx;
      mfa_q    <= mfa;
      err_q    <= err_nx;
      wait_cnt <= wait_nx;
      if (state == IDLE && req) begin
        ld_q       <= ld;
        dword_q    <= dword;
        sgn_q      <= sgn;
        size_q     <= size;
        addr_q     <= addr;
        wdata_q    <= wdata;
        wdata_hi_q <= wdata_hi;
      end
      if (cap_lo) rdata    <= load_val;
      if (cap_hi) rdata_hi <= ram_rdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_ctrl
// Description : Randomized and directed bench for mem_access_ctrl. The bench
//               acts as the RAM, predicts every access cycle, latency and
//               load result from the request rules, and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst_n, mfa, ld, dword, sgn;
  logic [1:0]  size;
  logic [31:0] addr, wdata, wdata_hi;
  logic [31:0] rdata, rdata_hi;
  logic        moc, err, busy;
  logic        ram_en, ram_we;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic [3:0]  ram_be;
  logic        ram_ack;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] m_rdata, m_rdata_hi;
  bit          use_fixed = 1'b0;
  logic [31:0] fixed_rd  = 32'd0;

  mem_access_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .mfa(mfa), .ld(ld), .size(size), .dword(dword),
    .sgn(sgn), .addr(addr), .wdata(wdata), .wdata_hi(wdata_hi),
    .rdata(rdata), .rdata_hi(rdata_hi), .moc(moc), .err(err), .busy(busy),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_be(ram_be),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_ack(ram_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic is_bad(input logic [1:0] sz, input logic dw, input logic [31:0] a);
    if (dw) return a[2:0] != 3'b000;
    if (sz == 2'b11) return 1'b1;
    if (sz == 2'b00) return a[0];
    if (sz == 2'b10) return a[1:0] != 2'b00;
    return 1'b0;
  endfunction

  // Value a load of this shape should return for RAM word d.
  function automatic logic [31:0] extract(input logic [1:0] sz, input logic dw, input logic sg,
                                          input logic [31:0] a, input logic [31:0] d);
    logic [31:0] v;
    if (dw || sz == 2'b10) return d;
    if (sz == 2'b01) begin
      v = (d >> (8 * int'(a[1:0]))) & 32'h0000_00FF;
      if (sg && v[7]) v = v | 32'hFFFF_FF00;
    end else begin
      v = (d >> (16 * int'(a[1]))) & 32'h0000_FFFF;
      if (sg && v[15]) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_en"},    {31'd0, ram_en}, 32'd0);
    check({tag, "_we"},    {31'd0, ram_we}, 32'd0);
    check({tag, "_be"},    {28'd0, ram_be}, 32'd0);
    check({tag, "_addr"},  ram_addr,        32'd0);
    check({tag, "_wdata"}, ram_wdata,       32'd0);
    check({tag, "_moc"},   {31'd0, moc},    32'd0);
    check({tag, "_err"},   {31'd0, err},    32'd0);
    check({tag, "_busy"},  {31'd0, busy},   32'd0);
    check({tag, "_rd"},    rdata,           32'd0);
    check({tag, "_rdhi"},  rdata_hi,        32'd0);
  endtask

  // One request from a negedge: w0/w1 are ack wait cycles per access
  // (>= TIMEOUT means never acknowledged); abort_at>0 asserts reset at that cycle.
  task automatic run_req(input logic pre_low, input logic l, input logic [1:0] sz,
                         input logic dw, input logic sg, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] wdh,
                         input int w0, input int w1, input int abort_at);
    int waits[2];
    int len[2];
    int n_acc, total, k, p;
    logic bad, exp_err;
    logic [3:0] exp_be;
    logic [31:0] exp_wd;
    waits[0] = w0; waits[1] = w1; len[0] = 0; len[1] = 0;
    if (pre_low) begin
      mfa = 1'b0;
      @(negedge clk);
    end
    ld = l; size = sz; dword = dw; sgn = sg; addr = a; wdata = wd; wdata_hi = wdh;
    mfa = 1'b1; ram_ack = 1'b0;
    bad = is_bad(sz, dw, a);
    exp_err = bad;
    n_acc = bad ? 0 : (dw ? 2 : 1);
    total = 1;
    for (int i = 0; i < n_acc; i++) begin
      if (waits[i] < TIMEOUT) begin
        len[i] = waits[i] + 1;
      end else begin
        len[i] = TIMEOUT;
        exp_err = 1'b1;
      end
      total += len[i];
      if (waits[i] >= TIMEOUT) break;
    end
    for (int c = 1; c <= total; c++) begin
      @(negedge clk);
      check("busy", {31'd0, busy}, 32'd1);
      if (c < total) begin
        k = (c <= len[0]) ? 0 : 1;
        p = (k == 0) ? c : c - len[0];
        if (dw) begin
          exp_be = 4'b1111;
          exp_wd = (k == 0) ? wd : wdh;
        end else if (sz == 2'b01) begin
          exp_be = 4'b0001 << a[1:0];
          exp_wd = {4{wd[7:0]}};
        end else if (sz == 2'b00) begin
          exp_be = a[1] ? 4'b1100 : 4'b0011;
          exp_wd = {2{wd[15:0]}};
        end else begin
          exp_be = 4'b1111;
          exp_wd = wd;
        end
        check("ram_en",   {31'd0, ram_en}, 32'd1);
        check("ram_we",   {31'd0, ram_we}, {31'd0, ~l});
        check("ram_addr", ram_addr, (a & ~32'd3) + 32'(4 * k));
        check("ram_be",   {28'd0, ram_be}, {28'd0, exp_be});
        if (!l) check("ram_wdata", ram_wdata, exp_wd);
        check("moc_early", {31'd0, moc}, 32'd0);
        if (abort_at == c) begin
          rst_n = 1'b0;
          return;
        end
        ram_rdata = use_fixed ? fixed_rd : $urandom;
        ram_ack   = (p == waits[k] + 1);
        if (ram_ack && l) begin
          if (k == 0) m_rdata = extract(sz, dw, sg, a, ram_rdata);
          else        m_rdata_hi = ram_rdata;
        end
      end else begin
        check("moc",      {31'd0, moc},    32'd1);
        check("err",      {31'd0, err},    {31'd0, exp_err});
        check("en_done",  {31'd0, ram_en}, 32'd0);
        check("rdata",    rdata,           m_rdata);
        check("rdata_hi", rdata_hi,        m_rdata_hi);
        ram_ack   = 1'($urandom);
        ram_rdata = $urandom;
      end
    end
    @(negedge clk);
    check("moc_after",  {31'd0, moc},  32'd0);
    check("busy_after", {31'd0, busy}, 32'd0);
    check("rd_hold",    rdata,         m_rdata);
    ram_ack = 1'b0;
  endtask

  initial begin
    logic [1:0]  r_sz;
    logic [31:0] r_a;
    logic        r_dw;
    int          r_w0, r_w1;

    rst_n = 1'b0; mfa = 1'b0; ld = 1'b0; size = 2'b00; dword = 1'b0; sgn = 1'b0;
    addr = 32'd0; wdata = 32'd0; wdata_hi = 32'd0; ram_rdata = 32'd0; ram_ack = 1'b0;
    m_rdata = 32'd0; m_rdata_hi = 32'd0;
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("rst0");
    rst_n = 1'b1;
    @(negedge clk);

    // Signed byte load from the top lane.
    use_fixed = 1'b1; fixed_rd = 32'h80AA_BBCC;
    run_req(1'b1, 1'b1, 2'b01, 1'b0, 1'b1, 32'h0000_0103, 32'd0, 32'd0, 0, 0, 0);
    use_fixed = 1'b0;
    check("lb_sext", rdata, 32'hFFFF_FF80);

    // Halfword store to the upper half of a word.
    run_req(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0000_0022, 32'h1234_ABCD, 32'd0, 0, 0, 0);

    // Doubleword load with two wait cycles per access.
    run_req(1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 32'h0000_0040, 32'd0, 32'd0, 2, 2, 0);

    // Misaligned word load: no RAM cycle, error, data held.
    run_req(1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 32'h0000_0002, 32'd0, 32'd0, 0, 0, 0);

    // Word store never acknowledged, then mfa stays high.
    run_req(1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 32'd0, TIMEOUT, 0, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("held_en",   {31'd0, ram_en}, 32'd0);
      check("held_busy", {31'd0, busy},   32'd0);
    end

    // Reset during the second access of a doubleword load.
    run_req(1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 32'h0000_0080, 32'd0, 32'd0, 1, 3, 3);
    @(negedge clk);
    check_reset_outputs("rst_mid");
    m_rdata = 32'd0; m_rdata_hi = 32'd0;
    // mfa still high through reset: the first cycle after release is a request.
    rst_n = 1'b1;
    run_req(1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 32'h0000_0206, 32'd0, 32'd0, 1, 0, 0);

    // Random requests.
    for (int n = 0; n < 200; n++) begin
      r_dw = ($urandom_range(0, 4) == 0);
      r_sz = 2'($urandom_range(0, 3));
      r_a  = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (r_dw)               r_a[2:0] = 3'b000;
        else if (r_sz == 2'b10) r_a[1:0] = 2'b00;
        else if (r_sz == 2'b00) r_a[0]   = 1'b0;
      end
      r_w0 = ($urandom_range(0, 19) == 0) ? TIMEOUT : int'($urandom_range(0, 3));
      r_w1 = int'($urandom_range(0, 3));
      run_req(1'b1, 1'($urandom), r_sz, r_dw, 1'($urandom), r_a, $urandom, $urandom,
              r_w0, r_w1, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15: maximum cycles waited for ram_ack per RAM cycle.
REQ-002 SHALL have one clock and a synchronous active-low reset: clk in 1 (rising-edge); rst_n in 1 (synchronous, active-low).
REQ-003 mfa in 1: memory function activate from control unit; a request is its 0->1 transition.
REQ-004 ld in 1: 1 = load, 0 = store (decoder L).
REQ-005 size in 2: access size from decoder WB; 10 word, 01 byte, 00 halfword, 11 illegal.
REQ-006 dword in 1: doubleword access (decoder D); overrides size.
REQ-007 sgn in 1: sign-extend byte/halfword loads when 1, else zero-extend.
REQ-008 addr in 32: byte address; wdata in 32: store data (low word); wdata_hi in 32: store data (second word of doubleword).
REQ-009 rdata out 32: load result (low word); rdata_hi out 32: second loaded word of doubleword.
REQ-010 moc out 1: memory operation complete, one-cycle pulse; err out 1: valid with moc, 1 = misaligned/illegal/timeout.
REQ-011 busy out 1: high from request accept until moc cycle inclusive.
REQ-012 RAM side: ram_en out 1; ram_we out 1; ram_addr out 32 (word-aligned, bits[1:0]=00); ram_be out 4; ram_wdata out 32; ram_rdata in 32; ram_ack in 1.

Function
REQ-013 States SHALL be IDLE, ACC1, ACC2, DONE.
REQ-014 In IDLE, mfa sampled 1 with previous-cycle mfa 0 SHALL latch ld/size/dword/sgn/addr/wdata/wdata_hi and move to ACC1, or to DONE with err=1 if checks fail (REQ-015); mfa held high SHALL NOT start a second request.
REQ-015 Checks: size=11 without dword, halfword with addr[0]=1, word with addr[1:0]!=00, dword with addr[2:0]!=000 -> error; no RAM cycle issued.
REQ-016 In ACC1/ACC2, ram_en=1, ram_we=~ld, ram_addr={addr[31:2],2'b00} (ACC2: +4); ram_en=0 in IDLE and DONE.
REQ-017 Byte lanes little-endian: byte be=0001<<addr[1:0], ram_wdata=wdata[7:0] replicated x4; halfword be=0011 or 1100 by addr[1], wdata[15:0] replicated x2; word/dword be=1111, wdata (ACC2: wdata_hi).
REQ-018 ram_ack sampled 1 in ACC1: load captures data into rdata (extracted lane, extended per sgn; word unmodified); next state ACC2 if dword else DONE.
REQ-019 ram_ack sampled 1 in ACC2: load captures ram_rdata into rdata_hi; next DONE.
REQ-020 4-bit wait counter SHALL clear on each ACC entry and increment each ACC cycle without ack; ack absent for TIMEOUT consecutive cycles -> DONE with err=1, remaining access abandoned.
REQ-021 DONE lasts exactly one cycle: moc=1, busy=1, err valid; then IDLE.
REQ-022 Zero-wait latency: mfa rise sampled at edge E0, ack high in ACC1 -> moc high in cycle after E1; dword adds one cycle per access plus wait cycles.
REQ-023 rdata/rdata_hi SHALL hold until next load captures; stores and errored requests leave them unchanged.
REQ-024 ram_ack outside ACC1/ACC2 SHALL be ignored; mfa changes during ACC/DONE SHALL be ignored except for edge tracking.

Reset
REQ-025 rst_n sampled 0 at any edge, including mid-access, SHALL force IDLE, ram_en=0, ram_we=0, ram_be=0000, ram_addr=0, ram_wdata=0, moc=0, err=0, busy=0, rdata=0, rdata_hi=0, wait counter=0, mfa edge register=0.
REQ-026 After reset release, mfa already high SHALL count as a rising edge on the first sampled cycle.

Verification
REQ-027 Load byte, addr=0x103, sgn=1, ram_rdata=0x80AABBCC, zero-wait -> ram_be=1000, rdata=0xFFFFFF80, moc one cycle after ACC1, err=0.
REQ-028 Store halfword, addr=0x22, wdata=0x1234ABCD -> ram_addr=0x20, ram_be=1100, ram_wdata=0xABCDABCD, ram_we=1, moc, err=0.
REQ-029 Load dword, addr=0x40, ack after 2 wait cycles each access -> ram_addr 0x40 then 0x44, rdata/rdata_hi = two returned words, moc 7 cycles after accept.
REQ-030 Load word addr=0x02 -> no ram_en, moc with err=1 one cycle after accept, rdata unchanged.
REQ-031 Store word, ram_ack held 0 -> ram_en drops after 15 cycles, moc with err=1; mfa held high afterwards -> no new access.
REQ-032 rst_n low during ACC2 of dword -> next cycle all outputs at reset values, state IDLE.
